// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: one FA slice reused for WIDTH cycles, LSB-first.
// Optional subtract mode enabled by defining SERIAL_SUB_EN (adds port sub_in).

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_seq #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
`ifdef SERIAL_SUB_EN
  input  logic             sub_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last;
  logic [WIDTH-1:0] b_load;
  logic             c_load;

  fa_cell u_fa (
    .a  (a_sr[0]),
    .b  (b_sr[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last = (cnt == CNT_W'(WIDTH - 1));

  // Operand B and carry as loaded at accept (inverted B + 1 for subtract)
`ifdef SERIAL_SUB_EN
  assign b_load = sub_in ? ~b_in : b_in;
  assign c_load = sub_in ? 1'b1 : cin_in;
`else
  assign b_load = b_in;
  assign c_load = cin_in;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and one serial add step per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr   <= a_in;
      b_sr   <= b_load;
      sum_sr <= '0;
      carry  <= c_load;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + 1'b1;
    end
  end

  assign sum_out  = sum_sr;
  assign cout_out = carry;

endmodule

// File: tb/tb_serial_add_seq.sv
// Self-checking bench for serial_add_seq (WIDTH=4).
// Table vectors, random ops vs arithmetic model, stall and reset cases.

module tb_serial_add_seq;
  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         cin_in;
`ifdef SERIAL_SUB_EN
  logic         sub_in;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum_out;
  logic         cout_out;
  logic         busy;

  int n_tests;
  int n_fail;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin_in    (cin_in),
`ifdef SERIAL_SUB_EN
    .sub_in    (sub_in),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum_out   (sum_out),
    .cout_out  (cout_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction; operands scrambled during RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic sub,
                        input int stall, input string tag,
                        input logic [W-1:0] es, input logic ec);
    int lat;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    a_in      = a;
    b_in      = b;
    cin_in    = ci;
`ifdef SERIAL_SUB_EN
    sub_in    = sub;
`endif
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      a_in     = W'($urandom);
      b_in     = W'($urandom);
      cin_in   = 1'($urandom);
`ifdef SERIAL_SUB_EN
      sub_in   = 1'($urandom);
`endif
      if (!out_valid) begin
        @(posedge clk);
        lat++;
      end
    end while (!out_valid && lat <= W + 4);
    chk({tag, " latency"}, 32'(lat), 32'(W));
    chk({tag, " sum"}, 32'(sum_out), 32'(es));
    chk({tag, " cout"}, 32'(cout_out), 32'(ec));
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk({tag, " stall valid"}, 32'(out_valid), 32'd1);
      chk({tag, " stall ready"}, 32'(in_ready), 32'd0);
      chk({tag, " stall sum"}, {27'd0, cout_out, sum_out}, {27'd0, ec, es});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " back idle"}, {30'd0, out_valid, in_ready}, 32'd1);
    chk({tag, " retain"}, {27'd0, cout_out, sum_out}, {27'd0, ec, es});
  endtask

  initial begin
    logic [W:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic rc;
    bit seen;
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin_in    = 1'b0;
`ifdef SERIAL_SUB_EN
    sub_in    = 1'b0;
`endif

    vecs[0] = '{4'b1011, 4'b0110, 1'b0, 4'b0001, 1'b1};
    vecs[1] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1};
    vecs[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0};
    vecs[3] = '{4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0};
    vecs[4] = '{4'b1000, 4'b1000, 1'b1, 4'b0001, 1'b1};
    vecs[5] = '{4'b0101, 4'b1010, 1'b1, 4'b0000, 1'b1};

    repeat (2) @(negedge clk);
    chk("reset outs", {25'd0, busy, out_valid, in_ready, cout_out, sum_out},
        {25'd0, 3'b001, 5'd0});
    rst = 1'b0;

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, 0, "vec",
             vecs[i].s, vecs[i].co);

    run_op(4'b1011, 4'b0110, 1'b0, 1'b0, 10, "bp", 4'b0001, 1'b1);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      m  = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
      run_op(ra, rb, rc, 1'b0, $urandom_range(0, 3), "rnd",
             m[W-1:0], m[W]);
    end

    // Abort mid-RUN with an asynchronous reset
    @(negedge clk);
    a_in = 4'b1111; b_in = 4'b0001; cin_in = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst mid", {25'd0, busy, out_valid, in_ready, cout_out, sum_out},
        {25'd0, 3'b001, 5'd0});
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("no out after rst", 32'(seen), 32'd0);
    run_op(4'b1011, 4'b0110, 1'b0, 1'b0, 2, "post rst", 4'b0001, 1'b1);

`ifdef SERIAL_SUB_EN
    run_op(4'b0101, 4'b0111, 1'b0, 1'b1, 0, "sub1", 4'b1110, 1'b0);
    run_op(4'b0111, 4'b0101, 1'b0, 1'b1, 0, "sub2", 4'b0010, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
